// File: rtl/pipe_pkg.sv
// Shared defaults and control-bundle bit positions for pipeline stage buffers.
package pipe_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int CTRL_W_DEF    = 8;

    localparam int CTRL_WREG     = 0;
    localparam int CTRL_M2REG    = 1;
    localparam int CTRL_WMEM     = 2;
    localparam int CTRL_ALUIMM   = 3;
    localparam int CTRL_ALUC_LSB = 4;
    localparam int CTRL_ALUC_W   = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x WIDTH entry store for pipe_stage_buf.
// Async read, sync write, async reset to zero.
module pipe_buf_mem
    import pipe_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with DEPTH-entry buffer and flush.
// Define PIPE_BUBBLE_CTRL_EN to force out_ctrl to zero while out_valid=0.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = 2,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CW-1:0]     count
);

    localparam int EW = DATA_W + CTRL_W;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop, wr_en;
    logic [EW-1:0] rd_entry;

    // Handshake flags come from registered count only.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    pipe_buf_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({in_ctrl, in_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign count    = count_q;
    assign out_data = rd_entry[DATA_W-1:0];

`ifdef PIPE_BUBBLE_CTRL_EN
    assign out_ctrl = out_valid ? rd_entry[EW-1:DATA_W] : '0;
`else
    assign out_ctrl = rd_entry[EW-1:DATA_W];
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf (DATA_W=32, CTRL_W=8, DEPTH=2).
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;
    logic [39:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W (32),
        .CTRL_W (8),
        .DEPTH  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge, model the edge.
    task automatic cyc(input logic iv, input logic [31:0] d,
                       input logic [7:0] c, input logic ordy,
                       input logic fl);
        logic        mpush;
        logic        mpop;
        logic [39:0] head;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(sb.size() != 2));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            head = sb[0];
            chk("out_data", 64'(out_data), 64'(head[31:0]));
            chk("out_ctrl", 64'(out_ctrl), 64'(head[39:32]));
        end
`ifdef PIPE_BUBBLE_CTRL_EN
        else chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
`endif
        mpush = iv && (sb.size() != 2);
        mpop  = ordy && (sb.size() != 0);
        @(posedge clk);
        #1;
        if (mpop) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (mpush) sb.push_back({c, d});
    endtask

    logic [7:0] ctl_a;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        ctl_a = 8'((1 << CTRL_WREG) | (1 << CTRL_M2REG) |
                   (1 << CTRL_WMEM) | (1 << CTRL_ALUIMM) |
                   (((1 << CTRL_ALUC_W) - 1) << CTRL_ALUC_LSB));
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_ctrl", 64'(out_ctrl), 64'h0);

        // reset state then first push
        cyc(1'b1, 32'h0000_00AA, 8'h05, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);

        // fill, reject third, stall
        cyc(1'b1, 32'h11, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h33, 8'h03, 1'b0, 1'b0);

        // drain
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // streaming with pointer wrap
        for (int i = 1; i <= 10; i++)
            cyc(1'b1, 32'(i), 8'(i + 8'h40), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // flush while pushing
        cyc(1'b1, 32'h55, ctl_a, 1'b0, 1'b0);
        cyc(1'b1, 32'h66, 8'h0C, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, ctl_a, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 32'h88, 8'h08, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // async reset mid-stream with two held
        cyc(1'b1, 32'h99, 8'h09, 1'b0, 1'b0);
        cyc(1'b1, 32'hBB, 8'h0B, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_valid", 64'(out_valid), 64'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h77, 8'h07, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
